// File: rtl/alu_resp_mon_pkg.sv
// Shared types and helpers for the ALU response monitor.
package alu_resp_mon_pkg;

  // Checking-session states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  // Saturating increment for a counter of width w (w <= 32), computed on a
  // 32-bit zero-extended copy; the caller casts back to its own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] maxv;
    maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= maxv) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/alu_resp_mon_fifo.sv
// Expected-value FIFO for the response monitor. Head data is read
// combinationally so the pop and the compare happen in the same cycle.
// Pointers carry one extra wrap bit to tell full from empty.
module alu_resp_mon_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head    = mem[rd_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

  // Read/write pointers, cleared at the start of every session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/alu_resp_monitor.sv
// In-order response checker: expected values are queued on a ready/valid
// port, observed results arrive valid-only and are compared against the
// oldest expected entry. Optional result signature (MISR) is enabled by
// defining ALU_RESP_MON_MISR_EN, which adds the sig output.
module alu_resp_monitor
  import alu_resp_mon_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             exp_valid,
  input  logic [W-1:0]     exp_data,
  output logic             exp_ready,
  input  logic             obs_valid,
  input  logic [W-1:0]     obs_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [CNT_W-1:0] unfl_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             mism_valid,
  output logic [W-1:0]     mism_exp,
  output logic [W-1:0]     mism_obs
`ifdef ALU_RESP_MON_MISR_EN
  ,
  output logic [W-1:0]     sig
`endif
);

  mon_state_e state_q, state_d;
  logic       session_start;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [W-1:0] fifo_head;
  logic       obs_run, cmp_pop, cmp_hit, cmp_mis, unfl_ev, miss_ev;
  logic [3:0] cnt_ev;
  logic [3:0][CNT_W-1:0] cnt_all;
  logic       err_q, mism_valid_q;
  logic [W-1:0] mism_exp_q, mism_obs_q;

  // Session FSM next-state; start only acts from IDLE/DONE and beats stop there.
  always_comb begin
    state_d       = state_q;
    session_start = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d       = RUN;
        session_start = 1'b1;
      end
      RUN:   if (stop) state_d = DRAIN;
      DRAIN: if (fifo_empty) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Full blocks pushes even if a pop frees a slot in the same cycle.
  assign exp_ready = (state_q == RUN) && !fifo_full;
  assign fifo_push = exp_valid && exp_ready;
  assign obs_run   = (state_q == RUN) && obs_valid;
  assign cmp_pop   = obs_run && !fifo_empty;
  assign cmp_mis   = cmp_pop && (fifo_head != obs_data);
  assign cmp_hit   = cmp_pop && (fifo_head == obs_data);
  assign unfl_ev   = obs_run && fifo_empty;
  assign miss_ev   = (state_q == DRAIN) && !fifo_empty;
  assign fifo_pop  = cmp_pop || miss_ev;
  assign cnt_ev    = {miss_ev, unfl_ev, cmp_mis, cmp_hit};

  alu_resp_mon_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (session_start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (exp_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Event counters: 0 match, 1 mismatch, 2 underflow, 3 missing.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_cnt
    logic [CNT_W-1:0] cnt_q;
    // Saturating counter, cleared when a session starts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             cnt_q <= '0;
      else if (session_start) cnt_q <= '0;
      else if (cnt_ev[gi])    cnt_q <= CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    end
    assign cnt_all[gi] = cnt_q;
  end

  // Sticky error flag and last-mismatch capture (registered, one cycle late).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q        <= 1'b0;
      mism_valid_q <= 1'b0;
      mism_exp_q   <= '0;
      mism_obs_q   <= '0;
    end else begin
      mism_valid_q <= cmp_mis;
      if (session_start)                     err_q <= 1'b0;
      else if (cmp_mis || unfl_ev || miss_ev) err_q <= 1'b1;
      if (cmp_mis) begin
        mism_exp_q <= fifo_head;
        mism_obs_q <= obs_data;
      end
    end
  end

`ifdef ALU_RESP_MON_MISR_EN
  logic [W-1:0] sig_q;
  // Rotate-and-xor signature over every observation taken during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             sig_q <= '0;
    else if (session_start) sig_q <= '0;
    else if (obs_run)       sig_q <= {sig_q[W-2:0], sig_q[W-1]} ^ obs_data;
  end
  assign sig = sig_q;
`endif

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign match_cnt  = cnt_all[0];
  assign mism_cnt   = cnt_all[1];
  assign unfl_cnt   = cnt_all[2];
  assign miss_cnt   = cnt_all[3];
  assign mism_valid = mism_valid_q;
  assign mism_exp   = mism_exp_q;
  assign mism_obs   = mism_obs_q;

endmodule

// File: tb/tb_alu_resp_monitor.sv
// Bench for alu_resp_monitor: directed steps plus a randomized run, each
// cycle checked against a queue-based reference model.
module tb_alu_resp_monitor;
  localparam int W     = 9;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n, start, stop, exp_valid, exp_ready, obs_valid;
  logic [W-1:0] exp_data, obs_data, mism_exp, mism_obs;
  logic busy, done, err, mism_valid;
  logic [CW-1:0] match_cnt, mism_cnt, unfl_cnt, miss_cnt;
`ifdef ALU_RESP_MON_MISR_EN
  logic [W-1:0] sig;
`endif

  always #5 clk = ~clk;

  alu_resp_monitor #(.W(W), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .exp_valid  (exp_valid),
    .exp_data   (exp_data),
    .exp_ready  (exp_ready),
    .obs_valid  (obs_valid),
    .obs_data   (obs_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .match_cnt  (match_cnt),
    .mism_cnt   (mism_cnt),
    .unfl_cnt   (unfl_cnt),
    .miss_cnt   (miss_cnt),
    .mism_valid (mism_valid),
    .mism_exp   (mism_exp),
    .mism_obs   (mism_obs)
`ifdef ALU_RESP_MON_MISR_EN
    ,
    .sig        (sig)
`endif
  );

  // Reference model state.
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} m_state_t;
  m_state_t     m_st;
  logic [W-1:0] m_q[$];
  int           m_match, m_mism, m_unfl, m_miss;
  logic         m_err, m_mv;
  logic [W-1:0] m_mexp, m_mobs, m_sig;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_q.delete();
    m_match = 0; m_mism = 0; m_unfl = 0; m_miss = 0;
    m_err = 1'b0; m_mv = 1'b0; m_mexp = '0; m_mobs = '0; m_sig = '0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ":busy"},       32'(busy),       32'(m_st == M_RUN || m_st == M_DRAIN));
    chk({tag, ":done"},       32'(done),       32'(m_st == M_DONE));
    chk({tag, ":err"},        32'(err),        32'(m_err));
    chk({tag, ":match_cnt"},  32'(match_cnt),  m_match);
    chk({tag, ":mism_cnt"},   32'(mism_cnt),   m_mism);
    chk({tag, ":unfl_cnt"},   32'(unfl_cnt),   m_unfl);
    chk({tag, ":miss_cnt"},   32'(miss_cnt),   m_miss);
    chk({tag, ":mism_valid"}, 32'(mism_valid), 32'(m_mv));
    chk({tag, ":mism_exp"},   32'(mism_exp),   32'(m_mexp));
    chk({tag, ":mism_obs"},   32'(mism_obs),   32'(m_mobs));
`ifdef ALU_RESP_MON_MISR_EN
    chk({tag, ":sig"},        32'(sig),        32'(m_sig));
`endif
  endtask

  // One clock cycle: drive inputs, check exp_ready, advance the model,
  // clock the DUT and compare all outputs.
  task automatic step(input string tag, input logic st, input logic sp,
                      input logic ev, input logic [W-1:0] ed,
                      input logic ov, input logic [W-1:0] od);
    logic rdy;
    logic [W-1:0] h;
    start = st; stop = sp; exp_valid = ev; exp_data = ed;
    obs_valid = ov; obs_data = od;
    rdy = (m_st == M_RUN) && (m_q.size() < DEPTH);
    #1;
    chk({tag, ":exp_ready"}, 32'(exp_ready), 32'(rdy));
    m_mv = 1'b0;
    case (m_st)
      M_IDLE, M_DONE: if (st) begin
        m_st = M_RUN; m_q.delete();
        m_match = 0; m_mism = 0; m_unfl = 0; m_miss = 0;
        m_err = 1'b0; m_sig = '0;
      end
      M_RUN: begin
        if (ov) begin
          m_sig = {m_sig[W-2:0], m_sig[W-1]} ^ od;
          if (m_q.size() > 0) begin
            h = m_q.pop_front();
            if (h == od) m_match = sat(m_match);
            else begin
              m_mism = sat(m_mism); m_err = 1'b1;
              m_mv = 1'b1; m_mexp = h; m_mobs = od;
            end
          end else begin
            m_unfl = sat(m_unfl); m_err = 1'b1;
          end
        end
        if (ev && rdy) m_q.push_back(ed);
        if (sp) m_st = M_DRAIN;
      end
      M_DRAIN: begin
        if (m_q.size() == 0) m_st = M_DONE;
        else begin
          void'(m_q.pop_front());
          m_miss = sat(m_miss); m_err = 1'b1;
        end
      end
      default: ;
    endcase
    @(posedge clk); #1;
    compare_all(tag);
    $display("%s st=%0b sp=%0b ev=%0b ed=%03h ov=%0b od=%03h -> busy=%0b done=%0b err=%0b m/x/u/s=%0d/%0d/%0d/%0d mv=%0b",
             tag, st, sp, ev, ed, ov, od, busy, done, err,
             match_cnt, mism_cnt, unfl_cnt, miss_cnt, mism_valid);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; exp_valid = 1'b0;
    exp_data = '0; obs_valid = 1'b0; obs_data = '0;
    model_reset();
    #12;
    compare_all("reset");
    chk("reset:exp_ready", 32'(exp_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: three in-order matches, then empty drain lasting one cycle.
    step("t1_start", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step("t1_push3", 1'b0, 1'b0, 1'b1, 9'd3, 1'b0, '0);
    step("t1_push5", 1'b0, 1'b0, 1'b1, 9'd5, 1'b0, '0);
    step("t1_push7", 1'b0, 1'b0, 1'b1, 9'd7, 1'b0, '0);
    step("t1_obs3",  1'b0, 1'b0, 1'b0, '0, 1'b1, 9'd3);
    step("t1_obs5",  1'b0, 1'b0, 1'b0, '0, 1'b1, 9'd5);
    step("t1_obs7",  1'b0, 1'b0, 1'b0, '0, 1'b1, 9'd7);
    chk("t1_match3", 32'(match_cnt), 32'd3);
    step("t1_stop",  1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("t1_drain_busy", 32'(busy), 32'd1);
    idle("t1_drain1");
    chk("t1_done", 32'(done), 32'd1);

    // 2: single mismatch with one-cycle pulse.
    step("t2_start", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step("t2_push",  1'b0, 1'b0, 1'b1, 9'h0AA, 1'b0, '0);
    step("t2_obs",   1'b0, 1'b0, 1'b0, '0, 1'b1, 9'h0AB);
    chk("t2_mism_exp", 32'(mism_exp), 32'h0AA);
    chk("t2_mism_obs", 32'(mism_obs), 32'h0AB);
    idle("t2_after");
    chk("t2_pulse_gone", 32'(mism_valid), 32'd0);

    // 3: fill FIFO, offer one more while full, drain as missing.
    step("t3_start", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH + 1; i++)
      step("t3_push", 1'b0, 1'b0, 1'b1, 9'(8'h10 + i), 1'b0, '0);
    step("t3_stop", 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH + 3 && !done; i++) idle("t3_drain");
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_miss8", 32'(miss_cnt), 32'd8);

    // 4: underflow with same-cycle push, then match of that push.
    step("t4_start", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step("t4_unfl",  1'b0, 1'b0, 1'b1, 9'd4, 1'b1, 9'd4);
    step("t4_obs4",  1'b0, 1'b0, 1'b0, '0, 1'b1, 9'd4);
    chk("t4_unfl1", 32'(unfl_cnt), 32'd1);
    chk("t4_match1", 32'(match_cnt), 32'd1);

    // 5: 18 mismatches saturate the counter, then reset mid-session.
    step("t5_start", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 19; i++)
      step("t5_mism", 1'b0, 1'b0, 1'b1, 9'(i), i > 0, 9'(i - 1) ^ 9'h100);
    chk("t5_sat", 32'(mism_cnt), 32'hF);
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all("t5_reset");
    chk("t5_reset:exp_ready", 32'(exp_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_RESP_MON_MISR_EN
    // 6: signature over two observations.
    step("t6_start", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step("t6_obs1",  1'b0, 1'b0, 1'b0, '0, 1'b1, 9'h001);
    chk("t6_sig1", 32'(sig), 32'h001);
    step("t6_obs2",  1'b0, 1'b0, 1'b0, '0, 1'b1, 9'h002);
    chk("t6_sig2", 32'(sig), 32'h000);
`endif

    // 7: randomized traffic, including start/stop while busy.
    step("t7_start", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 200; i++)
      step("t7_rand", ($urandom_range(0, 19) == 0), 1'b0,
           $urandom_range(0, 1) == 1, 9'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, 9'($urandom_range(0, 3)));
    step("t7_stop", 1'b0, 1'b1, 1'b1, 9'd1, 1'b1, 9'd1);
    for (int i = 0; i < DEPTH + 3 && !done; i++)
      step("t7_drain", 1'b0, 1'b0, 1'b0, '0, $urandom_range(0, 1) == 1, 9'd0);
    chk("t7_done", 32'(done), 32'd1);
    step("t7_restart_stop", 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("t7_start_wins", 32'(busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
